euler_frame_tx: RTL and testbench

- Downstream consumer of the BNO055 read sequencer.
- Accepts one Euler sample (yaw/roll/pitch, 16-bit raw counts) per strobe and serialises it into a fixed byte frame for the UART transmitter.
- Owns byte sequencing, the UART byte handshake, the checksum, one-deep latest-wins buffering of samples that arrive mid-frame, and a stuck-UART timeout.

---
 rtl/euler_frame_tx.sv | 175 +++++++++++++++++
 tb/tb_euler_frame_tx.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/euler_frame_tx.sv
// rtl/euler_frame_tx.sv - Euler sample to UART byte-frame serialiser
// Frames one yaw/roll/pitch sample per strobe; holds one latest-wins pending sample.
module euler_frame_tx #(
  parameter logic [7:0] START_BYTE       = 8'h53,
  parameter logic [7:0] END_BYTE         = 8'h0A,
  parameter bit         INCLUDE_CHECKSUM = 1'b1,
  parameter int         TX_TIMEOUT_CLKS  = 4096
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Sample_Valid,
  input  logic [15:0] i_Yaw,
  input  logic [15:0] i_Roll,
  input  logic [15:0] i_Pitch,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_DV,
  input  logic        i_TX_Active,
  input  logic        i_TX_Done,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic [7:0]  o_Overrun_Count,
  output logic        o_Error
);

  localparam logic [3:0] LAST_IDX = INCLUDE_CHECKSUM ? 4'd8 : 4'd7;
  localparam int TW = $clog2(TX_TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [47:0]   frame_q, frame_nxt;    // {yaw, roll, pitch}
  logic [47:0]   pend_q, pend_nxt;
  logic          pend_vld_q, pend_vld_nxt;
  logic [3:0]    idx_q, idx_nxt;
  logic [TW-1:0] tmo_q, tmo_nxt;
  logic [7:0]    byte_nxt;
  logic          dv_nxt, fdone_nxt, err_nxt;
  logic [7:0]    ovr_nxt;
  logic          ovr_inc, stash;
  logic [7:0]    chk, cur_byte;
  logic [47:0]   sample;

  assign sample = {i_Yaw, i_Roll, i_Pitch};
  assign chk    = frame_q[47:40] ^ frame_q[39:32] ^ frame_q[31:24] ^
                  frame_q[23:16] ^ frame_q[15:8]  ^ frame_q[7:0];
  assign o_Busy = (state != IDLE);

  always_comb begin
    case (idx_q)
      4'd0:    cur_byte = START_BYTE;
      4'd1:    cur_byte = frame_q[47:40];
      4'd2:    cur_byte = frame_q[39:32];
      4'd3:    cur_byte = frame_q[31:24];
      4'd4:    cur_byte = frame_q[23:16];
      4'd5:    cur_byte = frame_q[15:8];
      4'd6:    cur_byte = frame_q[7:0];
      4'd7:    cur_byte = INCLUDE_CHECKSUM ? chk : END_BYTE;
      default: cur_byte = END_BYTE;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    frame_nxt    = frame_q;
    pend_nxt     = pend_q;
    pend_vld_nxt = pend_vld_q;
    idx_nxt      = idx_q;
    tmo_nxt      = tmo_q;
    byte_nxt     = o_TX_Byte;
    dv_nxt       = 1'b0;
    fdone_nxt    = 1'b0;
    err_nxt      = o_Error;
    ovr_inc      = 1'b0;
    stash        = 1'b0;

    case (state)
      IDLE: begin
        if (i_Sample_Valid) begin
          frame_nxt = sample;
          idx_nxt   = 4'd0;
          state_nxt = SEND;
        end else if (pend_vld_q) begin
          frame_nxt    = pend_q;
          pend_vld_nxt = 1'b0;
          idx_nxt      = 4'd0;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        stash = i_Sample_Valid;
        if (!i_TX_Active) begin
          byte_nxt  = cur_byte;
          dv_nxt    = 1'b1;
          tmo_nxt   = '0;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tmo_nxt = tmo_q + 1'b1;
        if (i_TX_Done) begin
          if (idx_q < LAST_IDX) begin
            stash     = i_Sample_Valid;
            idx_nxt   = idx_q + 4'd1;
            state_nxt = SEND;
          end else begin
            // Frame boundary: a fresh strobe beats the pending sample.
            fdone_nxt = 1'b1;
            idx_nxt   = 4'd0;
            if (i_Sample_Valid) begin
              frame_nxt = sample;
              state_nxt = SEND;
              if (pend_vld_q) begin
                pend_vld_nxt = 1'b0;
                ovr_inc      = 1'b1;
              end
            end else if (pend_vld_q) begin
              frame_nxt    = pend_q;
              pend_vld_nxt = 1'b0;
              state_nxt    = SEND;
            end else begin
              state_nxt = IDLE;
            end
          end
        end else begin
          stash = i_Sample_Valid;
          if (tmo_q == TMO_LAST) begin
            err_nxt   = 1'b1;
            idx_nxt   = 4'd0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (stash) begin
      pend_nxt     = sample;
      pend_vld_nxt = 1'b1;
      if (pend_vld_q) ovr_inc = 1'b1;
    end

    ovr_nxt = (ovr_inc && (o_Overrun_Count != 8'hFF)) ? o_Overrun_Count + 8'd1
                                                      : o_Overrun_Count;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state           <= IDLE;
      frame_q         <= '0;
      pend_q          <= '0;
      pend_vld_q      <= 1'b0;
      idx_q           <= '0;
      tmo_q           <= '0;
      o_TX_Byte       <= '0;
      o_TX_DV         <= 1'b0;
      o_Frame_Done    <= 1'b0;
      o_Overrun_Count <= '0;
      o_Error         <= 1'b0;
    end else begin
      state           <= state_nxt;
      frame_q         <= frame_nxt;
      pend_q          <= pend_nxt;
      pend_vld_q      <= pend_vld_nxt;
      idx_q           <= idx_nxt;
      tmo_q           <= tmo_nxt;
      o_TX_Byte       <= byte_nxt;
      o_TX_DV         <= dv_nxt;
      o_Frame_Done    <= fdone_nxt;
      o_Overrun_Count <= ovr_nxt;
      o_Error         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_euler_frame_tx.sv
// tb/tb_euler_frame_tx.sv - scoreboard bench for euler_frame_tx
// Two builds (with/without checksum), each driven by a negedge UART responder model.
module tb_euler_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sv = 1'b0, sv0 = 1'b0;
  logic [15:0] yaw = '0, roll = '0, pitch = '0;
  logic [15:0] yaw0 = '0, roll0 = '0, pitch0 = '0;
  logic [7:0]  tx_byte, tx_byte0, ovr, ovr0;
  logic        tx_dv, tx_dv0, busy, busy0, fdone, fdone0, err, err0;
  logic        tx_active = 1'b0, tx_done = 1'b0;
  logic        tx_active0 = 1'b0, tx_done0 = 1'b0;

  euler_frame_tx dut (
    .i_Clk(clk), .i_Rst(rst), .i_Sample_Valid(sv),
    .i_Yaw(yaw), .i_Roll(roll), .i_Pitch(pitch),
    .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv),
    .i_TX_Active(tx_active), .i_TX_Done(tx_done),
    .o_Busy(busy), .o_Frame_Done(fdone),
    .o_Overrun_Count(ovr), .o_Error(err)
  );

  euler_frame_tx #(.INCLUDE_CHECKSUM(1'b0)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Sample_Valid(sv0),
    .i_Yaw(yaw0), .i_Roll(roll0), .i_Pitch(pitch0),
    .o_TX_Byte(tx_byte0), .o_TX_DV(tx_dv0),
    .i_TX_Active(tx_active0), .i_TX_Done(tx_done0),
    .o_Busy(busy0), .o_Frame_Done(fdone0),
    .o_Overrun_Count(ovr0), .o_Error(err0)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] q0[$];
  int dv_count = 0, fd_count = 0, dv_cyc = 0, done_cyc = 0;
  int dv_count0 = 0, fd_count0 = 0;
  int uart_delay = 4;
  int hang_at = -1;
  int exp_ovr = 0;
  bit u_busy = 0, u_busy0 = 0;
  int u_cnt = 0, u_cnt0 = 0;

  // UART responder and byte scoreboard, main build
  always @(negedge clk) begin
    logic [7:0] eb;
    if (rst) begin
      tx_active = 1'b0; tx_done = 1'b0; u_busy = 0;
    end else begin
      tx_done = 1'b0;
      if (fdone) fd_count++;
      if (tx_dv) begin
        dv_count++;
        dv_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %02h expected none", tx_byte);
        end else begin
          eb = q.pop_front();
          if (tx_byte !== eb) begin
            errors++;
            $display("FAIL tx_byte #%0d got %02h expected %02h", dv_count, tx_byte, eb);
          end
        end
        if (dv_count != hang_at) begin
          u_busy = 1; u_cnt = uart_delay; tx_active = 1'b1;
        end
      end else if (u_busy) begin
        if (u_cnt > 0) u_cnt--;
        else begin
          tx_done = 1'b1; tx_active = 1'b0; u_busy = 0; done_cyc = cyc;
        end
      end
    end
  end

  // UART responder and byte scoreboard, no-checksum build
  always @(negedge clk) begin
    logic [7:0] eb;
    if (rst) begin
      tx_active0 = 1'b0; tx_done0 = 1'b0; u_busy0 = 0;
    end else begin
      tx_done0 = 1'b0;
      if (fdone0) fd_count0++;
      if (tx_dv0) begin
        dv_count0++;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte0 got %02h expected none", tx_byte0);
        end else begin
          eb = q0.pop_front();
          if (tx_byte0 !== eb) begin
            errors++;
            $display("FAIL tx_byte0 #%0d got %02h expected %02h", dv_count0, tx_byte0, eb);
          end
        end
        u_busy0 = 1; u_cnt0 = 3; tx_active0 = 1'b1;
      end else if (u_busy0) begin
        if (u_cnt0 > 0) u_cnt0--;
        else begin
          tx_done0 = 1'b1; tx_active0 = 1'b0; u_busy0 = 0;
        end
      end
    end
  end

  function automatic logic [7:0] fbyte(input logic [15:0] y, input logic [15:0] r,
                                       input logic [15:0] p, input int i);
    logic [7:0] b [0:6];
    b[0] = 8'h53; b[1] = y[15:8]; b[2] = y[7:0]; b[3] = r[15:8];
    b[4] = r[7:0]; b[5] = p[15:8]; b[6] = p[7:0];
    if (i < 7) return b[i];
    if (i == 7) return b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    return 8'h0A;
  endfunction

  task automatic push_frame(input logic [15:0] y, input logic [15:0] r,
                            input logic [15:0] p, input int nbytes);
    for (int i = 0; i < nbytes; i++) q.push_back(fbyte(y, r, p, i));
  endtask

  int s_cyc = 0;
  task automatic strobe(input logic [15:0] y, input logic [15:0] r, input logic [15:0] p);
    @(negedge clk);
    s_cyc = cyc;
    sv = 1'b1; yaw = y; roll = r; pitch = p;
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    int n = 0;
    while (fd_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (fd_count < target) begin
      errors++;
      $display("FAIL %s_frame_done_timeout got %0d expected %0d", name, fd_count, target);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_dv(input int target, input int budget, input string name);
    int n = 0;
    while (dv_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (dv_count < target) begin
      errors++;
      $display("FAIL %s_dv_timeout got %0d expected %0d", name, dv_count, target);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({tx_byte, tx_dv, busy, fdone, ovr, err, tx_byte0, tx_dv0, busy0, fdone0, ovr0, err0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0",
               {tx_byte, tx_dv, busy, fdone, ovr, err, tx_byte0, tx_dv0, busy0, fdone0, ovr0, err0});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int bdv = dv_count, bfd = fd_count;
    q.push_back(8'h53); q.push_back(8'h12); q.push_back(8'h34);
    q.push_back(8'hFF); q.push_back(8'h9C); q.push_back(8'h00);
    q.push_back(8'h50); q.push_back(8'h15); q.push_back(8'h0A);
    strobe(16'h1234, 16'hFF9C, 16'h0050);
    wait_dv(bdv + 1, 20, "basic_first");
    checks++;
    if (dv_cyc !== s_cyc + 2) begin
      errors++;
      $display("FAIL basic_latency got %0d expected %0d", dv_cyc - s_cyc, 2);
    end
    wait_fd(bfd + 1, 500, "basic");
    checks++;
    if (dv_count - bdv !== 9) begin
      errors++;
      $display("FAIL basic_dv_count got %0d expected 9", dv_count - bdv);
    end
    checks++;
    if (fd_count - bfd !== 1 || ovr !== 8'(exp_ovr)) begin
      errors++;
      $display("FAIL basic_done_ovr got fd=%0d ovr=%0d expected fd=1 ovr=%0d",
               fd_count - bfd, ovr, exp_ovr);
    end
  endtask

  task automatic test_overrun;
    int bdv = dv_count, bfd = fd_count;
    push_frame(16'hA001, 16'hA002, 16'hA003, 9);
    push_frame(16'hC001, 16'hC0F2, 16'h0C03, 9);
    strobe(16'hA001, 16'hA002, 16'hA003);
    wait_dv(bdv + 3, 100, "overrun_byte2");
    strobe(16'hB001, 16'hB002, 16'hB003);
    strobe(16'hC001, 16'hC0F2, 16'h0C03);
    exp_ovr = exp_ovr + 1;
    wait_fd(bfd + 2, 1000, "overrun");
    checks++;
    if (ovr !== 8'(exp_ovr) || dv_count - bdv !== 18 || q.size() != 0) begin
      errors++;
      $display("FAIL overrun got ovr=%0d dv=%0d left=%0d expected ovr=%0d dv=18 left=0",
               ovr, dv_count - bdv, q.size(), exp_ovr);
    end
  endtask

  task automatic test_back_to_back;
    int bdv = dv_count, bfd = fd_count, n = 0;
    push_frame(16'h0101, 16'h0202, 16'h0303, 9);
    strobe(16'h0101, 16'h0202, 16'h0303);
    while (!(tx_done && dv_count == bdv + 9) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    push_frame(16'hD00D, 16'h7E57, 16'h4242, 9);
    sv = 1'b1; yaw = 16'hD00D; roll = 16'h7E57; pitch = 16'h4242;
    @(negedge clk);
    sv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy_gap cycle %0d got %b expected 1", i, busy);
      end
    end
    wait_dv(bdv + 10, 20, "b2b_start");
    checks++;
    if (dv_cyc - done_cyc > 2 || dv_cyc - done_cyc < 1) begin
      errors++;
      $display("FAIL b2b_start_latency got %0d expected <=2", dv_cyc - done_cyc);
    end
    wait_fd(bfd + 2, 1000, "b2b");
    checks++;
    if (ovr !== 8'(exp_ovr) || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_ovr got %0d left=%0d expected %0d left=0", ovr, q.size(), exp_ovr);
    end
  endtask

  task automatic test_timeout;
    int bdv = dv_count, bfd = fd_count, n = 0;
    hang_at = bdv + 4;
    push_frame(16'hEEEE, 16'h1111, 16'h2222, 4);
    strobe(16'hEEEE, 16'h1111, 16'h2222);
    while (!err && n < 6000) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (err !== 1'b1 || cyc - dv_cyc !== 4096) begin
      errors++;
      $display("FAIL timeout_error got err=%b after=%0d expected err=1 after=4096",
               err, cyc - dv_cyc);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || fd_count !== bfd || q.size() != 0) begin
      errors++;
      $display("FAIL timeout_abort got busy=%b fd=%0d left=%0d expected busy=0 fd=0 left=0",
               busy, fd_count - bfd, q.size());
    end
    hang_at = -1;
    push_frame(16'hF0F0, 16'h0F0F, 16'h5A5A, 9);
    strobe(16'hF0F0, 16'h0F0F, 16'h5A5A);
    wait_fd(bfd + 1, 500, "after_timeout");
    checks++;
    if (err !== 1'b1 || dv_count - bdv !== 13) begin
      errors++;
      $display("FAIL timeout_recover got err=%b dv=%0d expected err=1 dv=13", err, dv_count - bdv);
    end
  endtask

  task automatic test_saturation;
    int bfd = fd_count;
    uart_delay = 50;
    push_frame(16'd1, 16'hA5A5, 16'd7, 9);
    push_frame(16'(304 * 3 + 1), 16'(304) ^ 16'hA5A5, 16'(304 + 7), 9);
    for (int i = 0; i < 305; i++) begin
      @(negedge clk);
      sv = 1'b1; yaw = 16'(i * 3 + 1); roll = 16'(i) ^ 16'hA5A5; pitch = 16'(i + 7);
    end
    @(negedge clk);
    sv = 1'b0;
    exp_ovr = 255;
    wait_fd(bfd + 2, 3000, "saturation");
    checks++;
    if (ovr !== 8'(exp_ovr) || q.size() != 0) begin
      errors++;
      $display("FAIL saturation got ovr=%0d left=%0d expected ovr=255 left=0", ovr, q.size());
    end
    uart_delay = 4;
  endtask

  task automatic test_no_checksum;
    int bdv = dv_count0, bfd = fd_count0, n = 0;
    q0.push_back(8'h53); q0.push_back(8'h12); q0.push_back(8'h34); q0.push_back(8'hFF);
    q0.push_back(8'h9C); q0.push_back(8'h00); q0.push_back(8'h50); q0.push_back(8'h0A);
    @(negedge clk);
    sv0 = 1'b1; yaw0 = 16'h1234; roll0 = 16'hFF9C; pitch0 = 16'h0050;
    @(negedge clk);
    sv0 = 1'b0;
    while (fd_count0 < bfd + 1 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fd_count0 - bfd !== 1 || dv_count0 - bdv !== 8 || q0.size() != 0) begin
      errors++;
      $display("FAIL nochk_frame got fd=%0d dv=%0d left=%0d expected fd=1 dv=8 left=0",
               fd_count0 - bfd, dv_count0 - bdv, q0.size());
    end
  endtask

  task automatic test_reset_mid;
    int bdv = dv_count, bfd;
    uart_delay = 8;
    push_frame(16'h4321, 16'h8765, 16'hCBA9, 5);
    strobe(16'h4321, 16'h8765, 16'hCBA9);
    wait_dv(bdv + 5, 200, "reset_mid_byte4");
    strobe(16'h9999, 16'h8888, 16'h7777);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_byte, tx_dv, busy, fdone, ovr, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got %h expected 0", {tx_byte, tx_dv, busy, fdone, ovr, err});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ovr = 0;
    uart_delay = 4;
    repeat (200) @(negedge clk);
    #1;
    checks++;
    if (dv_count !== bdv + 5 || busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got dv=%0d busy=%b left=%0d expected dv=5 busy=0 left=0",
               dv_count - bdv, busy, q.size());
    end
    bfd = fd_count;
    push_frame(16'h0A0B, 16'h0C0D, 16'h0E0F, 9);
    strobe(16'h0A0B, 16'h0C0D, 16'h0E0F);
    wait_fd(bfd + 1, 500, "after_reset");
    checks++;
    if (err !== 1'b0 || ovr !== 8'(exp_ovr)) begin
      errors++;
      $display("FAIL after_reset_state got err=%b ovr=%0d expected err=0 ovr=0", err, ovr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_no_checksum();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
